// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: owns the single register-file write port. The fixed-latency
// pipeline writeback always wins; long-latency execution-unit results wait in
// a small FIFO and drain on cycles the pipeline leaves free. A per-register
// busy scoreboard tracks outstanding long-latency writes for the hazard unit.
module rf_wb_arbiter #(
   parameter int ADDR_LEN       = 5,
   parameter int DATA_WIDTH     = 32,
   parameter int REG_FILE_SIZE  = 32,
   parameter int EXT_FIFO_DEPTH = 2,
   parameter int STARVE_LIMIT   = 4
) (
   input  logic                     clk,
   input  logic                     nReset,
   input  logic                     pipe_valid,
   input  logic [ADDR_LEN-1:0]      pipe_reg,
   input  logic [DATA_WIDTH-1:0]    pipe_data,
   input  logic                     ext_valid,
   output logic                     ext_ready,
   input  logic [ADDR_LEN-1:0]      ext_reg,
   input  logic [DATA_WIDTH-1:0]    ext_data,
   input  logic                     alloc_valid,
   input  logic [ADDR_LEN-1:0]      alloc_reg,
   output logic [REG_FILE_SIZE-1:0] busy_vec,
   output logic                     pipe_stall,
   output logic                     waw_err,
   output logic                     writeEn,
   output logic [ADDR_LEN-1:0]      write_register,
   output logic [DATA_WIDTH-1:0]    write_data
);

   localparam int PTR_W    = (EXT_FIFO_DEPTH > 1) ? $clog2(EXT_FIFO_DEPTH) : 1;
   localparam int CNT_W    = $clog2(EXT_FIFO_DEPTH + 1);
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   logic [ADDR_LEN-1:0]      fifo_reg  [EXT_FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]    fifo_data [EXT_FIFO_DEPTH];
   logic [PTR_W-1:0]         rd_ptr;
   logic [PTR_W-1:0]         wr_ptr;
   logic [CNT_W-1:0]         count;
   logic [CNT_W-1:0]         count_next;
   logic [STARVE_W-1:0]      starve_cnt;
   logic [STARVE_W-1:0]      starve_next;
   logic [REG_FILE_SIZE-1:0] busy;
   logic [REG_FILE_SIZE-1:0] busy_next;
   logic                     stall;
   logic                     stall_next;
   logic                     waw;
   logic                     waw_next;
   logic                     fifo_empty;
   logic                     fifo_full;
   logic                     pipe_win;
   logic                     push;
   logic                     pop;
   logic [ADDR_LEN-1:0]      head_reg;
   logic [DATA_WIDTH-1:0]    head_data;

   // Starvation counter saturates at the limit so it never wraps back to zero.
   function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
      if (v >= STARVE_W'(STARVE_LIMIT)) begin
         return v;
      end
      return v + STARVE_W'(1);
   endfunction

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNT_W'(EXT_FIFO_DEPTH));
   assign head_reg   = fifo_reg[rd_ptr];
   assign head_data  = fifo_data[rd_ptr];

   // x0 writes from the pipeline do not claim the port, so the FIFO may drain.
   assign pipe_win = pipe_valid && (pipe_reg != '0);
   assign pop      = !pipe_win && !fifo_empty;
   assign push     = ext_valid && !fifo_full;

   // Space freed by a same-cycle pop is not offered until the next cycle.
   assign ext_ready = !fifo_full;

   // Port is combinational; an x0 head pops silently with the enable low.
   assign writeEn        = nReset && (pipe_win || (pop && (head_reg != '0)));
   assign write_register = pipe_win ? pipe_reg  : head_reg;
   assign write_data     = pipe_win ? pipe_data : head_data;

   assign busy_vec   = busy;
   assign pipe_stall = stall;
   assign waw_err    = waw;

   // Next-state for queue occupancy, starvation, stall request, scoreboard and WAW flag.
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase

      starve_next = starve_cnt;
      if (fifo_empty || pop) begin
         starve_next = '0;
      end else if (pipe_win) begin
         starve_next = sat_inc(starve_cnt);
      end

      // Raised on the edge the limit is reached; dropped on the edge the queue drains.
      stall_next = (count_next != '0) &&
                   (stall || (starve_next == STARVE_W'(STARVE_LIMIT)));

      // Clear on pop first so a same-cycle allocation of that register wins.
      busy_next = busy;
      if (pop) begin
         busy_next[head_reg] = 1'b0;
      end
      if (alloc_valid && (alloc_reg != '0)) begin
         busy_next[alloc_reg] = 1'b1;
      end
      busy_next[0] = 1'b0;

      waw_next = pipe_win && busy[pipe_reg];
   end

   // Control state; reset drops any queued results without writing them.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         starve_cnt <= '0;
         busy       <= '0;
         stall      <= 1'b0;
         waw        <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count      <= count_next;
         starve_cnt <= starve_next;
         busy       <= busy_next;
         stall      <= stall_next;
         waw        <= waw_next;
      end
   end

   // Queue storage carries data only; validity comes from the count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_reg[wr_ptr]  <= ext_reg;
         fifo_data[wr_ptr] <= ext_data;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based behavioural model.
module tb_rf_wb_arbiter;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int NR    = 32;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          nReset;
   logic          pipe_valid;
   logic [AW-1:0] pipe_reg;
   logic [DW-1:0] pipe_data;
   logic          ext_valid;
   logic          ext_ready;
   logic [AW-1:0] ext_reg;
   logic [DW-1:0] ext_data;
   logic          alloc_valid;
   logic [AW-1:0] alloc_reg;
   logic [NR-1:0] busy_vec;
   logic          pipe_stall;
   logic          waw_err;
   logic          writeEn;
   logic [AW-1:0] write_register;
   logic [DW-1:0] write_data;

   always #5 clk = ~clk;

   rf_wb_arbiter #(
      .ADDR_LEN(AW), .DATA_WIDTH(DW), .REG_FILE_SIZE(NR),
      .EXT_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .nReset(nReset),
      .pipe_valid(pipe_valid), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
      .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_reg(ext_reg), .ext_data(ext_data),
      .alloc_valid(alloc_valid), .alloc_reg(alloc_reg),
      .busy_vec(busy_vec), .pipe_stall(pipe_stall), .waw_err(waw_err),
      .writeEn(writeEn), .write_register(write_register), .write_data(write_data)
   );

   typedef struct packed {
      logic [AW-1:0] r;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          mq[$];
   logic [NR-1:0] m_busy;
   int            m_starve;
   logic          m_stall;
   logic          m_waw;
   bit            ext_taken;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs this cycle, from the model state and the present inputs.
   task automatic model_check();
      logic          pw;
      logic          e_en;
      logic [AW-1:0] e_r;
      logic [DW-1:0] e_d;
      pw   = pipe_valid && (pipe_reg != 0);
      e_en = 1'b0;
      e_r  = '0;
      e_d  = '0;
      if (nReset) begin
         if (pw) begin
            e_en = 1'b1; e_r = pipe_reg; e_d = pipe_data;
         end else if (mq.size() > 0) begin
            e_en = (mq[0].r != 0); e_r = mq[0].r; e_d = mq[0].d;
         end
      end
      chk("writeEn", 64'(writeEn), 64'(e_en));
      if (e_en) begin
         chk("write_register", 64'(write_register), 64'(e_r));
         chk("write_data", 64'(write_data), 64'(e_d));
      end
      chk("ext_ready", 64'(ext_ready), 64'(mq.size() < DEPTH));
      chk("busy_vec", 64'(busy_vec), 64'(m_busy));
      chk("pipe_stall", 64'(pipe_stall), 64'(m_stall));
      chk("waw_err", 64'(waw_err), 64'(m_waw));
   endtask

   // Advance the model across the coming clock edge.
   task automatic model_update();
      bit   pw;
      bit   was_empty;
      bit   popped;
      bit   took;
      ent_t e;
      ext_taken = 1'b0;
      if (!nReset) begin
         mq.delete();
         m_busy = '0; m_starve = 0; m_stall = 1'b0; m_waw = 1'b0;
      end else begin
         pw        = pipe_valid && (pipe_reg != 0);
         was_empty = (mq.size() == 0);
         popped    = !pw && !was_empty;
         took      = ext_valid && (mq.size() < DEPTH);
         m_waw     = pw && m_busy[pipe_reg];
         if (popped) begin
            m_busy[mq[0].r] = 1'b0;
            void'(mq.pop_front());
         end
         if (took) begin
            e.r = ext_reg; e.d = ext_data;
            mq.push_back(e);
         end
         if (alloc_valid && alloc_reg != 0) m_busy[alloc_reg] = 1'b1;
         m_busy[0] = 1'b0;
         if (was_empty || popped) m_starve = 0;
         else if (m_starve < LIMIT) m_starve++;
         m_stall   = (mq.size() > 0) && (m_stall || m_starve >= LIMIT);
         ext_taken = took;
      end
   endtask

   task automatic half();
      @(negedge clk);
      model_check();
   endtask

   task automatic adv();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      half();
      adv();
   endtask

   task automatic idle();
      pipe_valid = 1'b0; pipe_reg = '0; pipe_data = '0;
      ext_valid = 1'b0; ext_reg = '0; ext_data = '0;
      alloc_valid = 1'b0; alloc_reg = '0;
   endtask

   initial begin
      idle();
      nReset = 1'b0;
      pipe_valid = 1'b1; pipe_reg = 5'd5; pipe_data = 32'h5;
      repeat (2) begin
         @(negedge clk);
         model_update();
         @(posedge clk);
         #1;
      end

      // Reset held with a pipeline write pending.
      half();
      chk("rst_writeEn", 64'(writeEn), 64'd0);
      chk("rst_busy", 64'(busy_vec), 64'd0);
      chk("rst_ext_ready", 64'(ext_ready), 64'd1);
      chk("rst_stall", 64'(pipe_stall), 64'd0);
      adv();
      nReset = 1'b1;
      half();
      chk("rel_writeEn", 64'(writeEn), 64'd1);
      chk("rel_reg", 64'(write_register), 64'd5);
      adv();

      // Priority: pipeline beats a queued result.
      idle();
      pipe_valid = 1'b1; pipe_reg = 5'd3; pipe_data = 32'h1111;
      alloc_valid = 1'b1; alloc_reg = 5'd7;
      ext_valid = 1'b1; ext_reg = 5'd7; ext_data = 32'h1234;
      step();
      idle();
      pipe_valid = 1'b1; pipe_reg = 5'd3; pipe_data = 32'hAAAA5555;
      half();
      chk("prio_reg", 64'(write_register), 64'd3);
      chk("prio_data", 64'(write_data), 64'hAAAA5555);
      adv();
      idle();
      half();
      chk("drain_reg", 64'(write_register), 64'd7);
      chk("drain_data", 64'(write_data), 64'h1234);
      chk("drain_busy7_before", 64'(busy_vec[7]), 64'd1);
      adv();
      half();
      chk("drain_busy7_after", 64'(busy_vec[7]), 64'd0);
      adv();

      // Back-pressure with depth 2.
      idle();
      pipe_valid = 1'b1; pipe_reg = 5'd10; pipe_data = 32'hA0;
      ext_valid = 1'b1; ext_reg = 5'd1; ext_data = 32'h11;
      step();
      ext_reg = 5'd2; ext_data = 32'h22;
      step();
      ext_reg = 5'd3; ext_data = 32'h33;
      half();
      chk("full_ready", 64'(ext_ready), 64'd0);
      adv();
      pipe_valid = 1'b0;
      half();
      chk("full_pop_ready", 64'(ext_ready), 64'd0);
      chk("full_pop_reg", 64'(write_register), 64'd1);
      adv();
      half();
      chk("full_ready_again", 64'(ext_ready), 64'd1);
      chk("full_pop2_data", 64'(write_data), 64'h22);
      adv();
      ext_valid = 1'b0;
      half();
      chk("full_pop3_data", 64'(write_data), 64'h33);
      adv();
      step();

      // Starvation: four lost cycles raise the stall request.
      idle();
      alloc_valid = 1'b1; alloc_reg = 5'd9;
      ext_valid = 1'b1; ext_reg = 5'd9; ext_data = 32'h99;
      step();
      idle();
      pipe_valid = 1'b1; pipe_reg = 5'd4; pipe_data = 32'h44;
      repeat (3) step();
      half();
      chk("starve_stall_low", 64'(pipe_stall), 64'd0);
      adv();
      idle();
      half();
      chk("starve_stall_high", 64'(pipe_stall), 64'd1);
      chk("starve_drain_reg", 64'(write_register), 64'd9);
      adv();
      half();
      chk("starve_stall_clear", 64'(pipe_stall), 64'd0);
      adv();

      // Scoreboard set/clear race and WAW pulse.
      idle();
      alloc_valid = 1'b1; alloc_reg = 5'd6;
      step();
      idle();
      pipe_valid = 1'b1; pipe_reg = 5'd12; pipe_data = 32'hC;
      ext_valid = 1'b1; ext_reg = 5'd6; ext_data = 32'h66;
      step();
      idle();
      alloc_valid = 1'b1; alloc_reg = 5'd6;
      half();
      chk("race_pop_reg", 64'(write_register), 64'd6);
      adv();
      idle();
      pipe_valid = 1'b1; pipe_reg = 5'd6; pipe_data = 32'h6666;
      half();
      chk("race_busy6", 64'(busy_vec[6]), 64'd1);
      adv();
      idle();
      half();
      chk("waw_pulse", 64'(waw_err), 64'd1);
      adv();
      half();
      chk("waw_gone", 64'(waw_err), 64'd0);
      adv();

      // Register x0 from every source.
      idle();
      alloc_valid = 1'b1; alloc_reg = 5'd0;
      ext_valid = 1'b1; ext_reg = 5'd0; ext_data = 32'h5;
      pipe_valid = 1'b1; pipe_reg = 5'd0; pipe_data = 32'hF;
      half();
      chk("x0_writeEn_a", 64'(writeEn), 64'd0);
      adv();
      idle();
      pipe_valid = 1'b1; pipe_reg = 5'd0;
      half();
      chk("x0_writeEn_b", 64'(writeEn), 64'd0);
      chk("x0_busy0", 64'(busy_vec[0]), 64'd0);
      adv();
      idle();
      step();

      // Reset mid-operation discards queued results.
      pipe_valid = 1'b1; pipe_reg = 5'd1; pipe_data = 32'h1;
      ext_valid = 1'b1; ext_reg = 5'd8; ext_data = 32'h88;
      step();
      ext_reg = 5'd9; ext_data = 32'h99;
      step();
      idle();
      nReset = 1'b0;
      pipe_valid = 1'b1; pipe_reg = 5'd2;
      half();
      chk("midrst_writeEn", 64'(writeEn), 64'd0);
      adv();
      nReset = 1'b1;
      idle();
      half();
      chk("midrst_discard", 64'(writeEn), 64'd0);
      adv();

      // Randomized traffic; execution-unit offers are held until accepted.
      ext_taken = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         nReset      = ($urandom_range(0, 149) != 0);
         pipe_valid  = m_stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 6);
         pipe_reg    = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         pipe_data   = $urandom;
         if (!ext_valid || ext_taken) begin
            ext_valid = $urandom_range(0, 1) == 1;
            ext_reg   = AW'($urandom_range(0, 7));
            ext_data  = $urandom;
         end
         alloc_valid = ($urandom_range(0, 9) < 3);
         alloc_reg   = AW'($urandom_range(0, 7));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
